// File: rtl/decode_hazard_ctrl.sv
// ============================================================================
// Module   : decode_hazard_ctrl
// Purpose  : Decode-stage RAW hazard, branch flush and halt sequencing.
//            Optional macro DECODE_HAZARD_FORWARD_EN limits stalls to load-use.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decode_hazard_ctrl #(
  parameter int DEPTH = 2,
  parameter int WDOG  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [2:0]  readReg1,
  input  logic [2:0]  readReg2,
  input  logic        use_rs,
  input  logic        use_rt,
  input  logic [2:0]  writeReg,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        createdump,
  input  logic        flush_req,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        flush_ifid,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic        err
);

  localparam logic [1:0] c_RUN   = 2'd0;
  localparam logic [1:0] c_STALL = 2'd1;
  localparam logic [1:0] c_HALT  = 2'd2;
  localparam int         c_WDW   = $clog2(WDOG + 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [DEPTH:1]   r_sb_v;
  logic [DEPTH:1]   r_sb_ld;
  logic [2:0]       r_sb_reg [1:DEPTH];
  logic [DEPTH:1]   w_hit_rs;
  logic [DEPTH:1]   w_hit_rt;
  logic             w_hazard;
  logic             w_stall;
  logic             w_in_halt;
  logic             w_issue;
  logic [c_WDW-1:0] r_wd_cnt;
  logic             r_err;
  logic [15:0]      r_stall_cnt;

  // With forwarding only a load still sitting in EX can't be bypassed.
  for (genvar k = 1; k <= DEPTH; k++) begin : g_match
`ifdef DECODE_HAZARD_FORWARD_EN
    if (k == 1) begin : g_load_use
      assign w_hit_rs[k] = r_sb_v[k] & r_sb_ld[k] & (r_sb_reg[k] == readReg1);
      assign w_hit_rt[k] = r_sb_v[k] & r_sb_ld[k] & (r_sb_reg[k] == readReg2);
    end else begin : g_bypassed
      assign w_hit_rs[k] = 1'b0;
      assign w_hit_rt[k] = 1'b0;
    end
`else
    assign w_hit_rs[k] = r_sb_v[k] & (r_sb_reg[k] == readReg1);
    assign w_hit_rt[k] = r_sb_v[k] & (r_sb_reg[k] == readReg2);
`endif
  end

  assign w_in_halt = (r_state == c_HALT);
  assign w_hazard  = id_valid & ((use_rs & (|w_hit_rs)) | (use_rt & (|w_hit_rt)));
  assign w_stall   = w_hazard & ~flush_req & ~w_in_halt;
  assign w_issue   = id_valid & ~idex_bubble;

  always_comb begin
    pc_write    = ~w_stall;
    ifid_write  = ~w_stall;
    idex_bubble = w_stall | flush_req;
    flush_ifid  = flush_req;
    if (w_in_halt) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      flush_ifid  = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!w_in_halt) begin
      if (id_valid && createdump && !w_stall && !flush_req)
        w_state_nxt = c_HALT;
      else if (w_stall)
        w_state_nxt = c_STALL;
      else
        w_state_nxt = c_RUN;
    end
  end

  // Scoreboard keeps shifting in HALT so it drains to empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sb_v  <= '0;
      r_sb_ld <= '0;
      for (int k = 1; k <= DEPTH; k++) r_sb_reg[k] <= 3'd0;
    end else begin
      r_sb_v[1]   <= w_issue & RegWrite;
      r_sb_ld[1]  <= w_issue & MemRead;
      r_sb_reg[1] <= w_issue ? writeReg : 3'd0;
      for (int k = 2; k <= DEPTH; k++) begin
        r_sb_v[k]   <= r_sb_v[k-1];
        r_sb_ld[k]  <= r_sb_ld[k-1];
        r_sb_reg[k] <= r_sb_reg[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_RUN;
      r_stall_cnt <= 16'd0;
      r_wd_cnt    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_stall && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_stall) begin
        if (r_wd_cnt != c_WDW'(WDOG))
          r_wd_cnt <= r_wd_cnt + c_WDW'(1);
        if (r_wd_cnt >= c_WDW'(WDOG - 1))
          r_err <= 1'b1;
      end else begin
        r_wd_cnt <= '0;
      end
    end
  end

  assign halted    = w_in_halt;
  assign stall_cnt = r_stall_cnt;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_decode_hazard_ctrl.sv
// ============================================================================
// Module   : tb_decode_hazard_ctrl
// Purpose  : Directed + random checks of decode_hazard_ctrl against a
//            history-based reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_decode_hazard_ctrl;

  localparam int c_DEPTH = 2;
  localparam int c_WDOG  = 4;
`ifdef DECODE_HAZARD_FORWARD_EN
  localparam int c_EXP_RAW = 0;
  localparam int c_EXP_LD  = 1;
  localparam bit c_WD_ERR  = 1'b0;
`else
  localparam int c_EXP_RAW = 2;
  localparam int c_EXP_LD  = 2;
  localparam bit c_WD_ERR  = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 1'b0, use_rs = 1'b0, use_rt = 1'b0;
  logic [2:0]  readReg1 = 3'd0, readReg2 = 3'd0, writeReg = 3'd0;
  logic        RegWrite = 1'b0, MemRead = 1'b0, createdump = 1'b0, flush_req = 1'b0;
  logic        pc_write, ifid_write, idex_bubble, flush_ifid, halted, err;
  logic [15:0] stall_cnt;
  logic        pc_write_w, ifid_write_w, idex_bubble_w, flush_ifid_w, halted_w, err_w;
  logic [15:0] stall_cnt_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_hazard_ctrl #(.DEPTH(c_DEPTH), .WDOG(c_WDOG)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .readReg1(readReg1), .readReg2(readReg2),
    .use_rs(use_rs), .use_rt(use_rt), .writeReg(writeReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .createdump(createdump), .flush_req(flush_req),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
    .flush_ifid(flush_ifid), .halted(halted), .stall_cnt(stall_cnt), .err(err)
  );

  // Deeper instance: lets one producer hold a hazard long enough to trip the watchdog.
  decode_hazard_ctrl #(.DEPTH(4), .WDOG(c_WDOG)) dut_w (
    .clk(clk), .rst(rst), .id_valid(id_valid), .readReg1(readReg1), .readReg2(readReg2),
    .use_rs(use_rs), .use_rt(use_rt), .writeReg(writeReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .createdump(createdump), .flush_req(flush_req),
    .pc_write(pc_write_w), .ifid_write(ifid_write_w), .idex_bubble(idex_bubble_w),
    .flush_ifid(flush_ifid_w), .halted(halted_w), .stall_cnt(stall_cnt_w), .err(err_w)
  );

  // Reference model: list of what issued in recent cycles, newest first.
  typedef struct packed {bit v; bit [2:0] r; bit ld;} issue_t;
  issue_t hist[$];
  bit     m_halt;
  int     m_stall_cnt, m_wd;
  bit     m_err;
  bit     o_pc, o_ifid, o_bub, o_fl;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < c_DEPTH; i++) hist.push_back('0);
    m_halt = 1'b0; m_stall_cnt = 0; m_wd = 0; m_err = 1'b0;
  endtask

  function automatic bit busy(input logic [2:0] r);
    bit hit = 1'b0;
`ifdef DECODE_HAZARD_FORWARD_EN
    hit = hist[0].v && hist[0].ld && (hist[0].r == r);
`else
    for (int i = 0; i < c_DEPTH; i++)
      if (hist[i].v && hist[i].r == r) hit = 1'b1;
`endif
    return hit;
  endfunction

  task automatic set_in(input bit v, input bit [2:0] rs, input bit [2:0] rt, input bit urs,
                        input bit urt, input bit [2:0] wr, input bit rw, input bit ld,
                        input bit cd, input bit fl);
    id_valid = v; readReg1 = rs; readReg2 = rt; use_rs = urs; use_rt = urt;
    writeReg = wr; RegWrite = rw; MemRead = ld; createdump = cd; flush_req = fl;
  endtask

  // Check one cycle against the model, then advance model and clock together.
  task automatic tick();
    bit e_haz, e_stall, e_pc, e_bub, e_fl;
    issue_t ent;
    #1;
    e_haz   = id_valid && ((use_rs && busy(readReg1)) || (use_rt && busy(readReg2)));
    e_stall = e_haz && !flush_req && !m_halt;
    e_pc    = !m_halt && !e_stall;
    e_bub   = m_halt || e_stall || flush_req;
    e_fl    = !m_halt && flush_req;
    o_pc = pc_write; o_ifid = ifid_write; o_bub = idex_bubble; o_fl = flush_ifid;
    chk("pc_write", {15'd0, pc_write}, {15'd0, e_pc});
    chk("ifid_write", {15'd0, ifid_write}, {15'd0, e_pc});
    chk("idex_bubble", {15'd0, idex_bubble}, {15'd0, e_bub});
    chk("flush_ifid", {15'd0, flush_ifid}, {15'd0, e_fl});
    chk("halted", {15'd0, halted}, {15'd0, m_halt});
    chk("stall_cnt", stall_cnt, m_stall_cnt[15:0]);
    chk("err", {15'd0, err}, {15'd0, m_err});
    @(posedge clk);
    ent = (id_valid && !e_bub) ? issue_t'({RegWrite, writeReg, MemRead}) : issue_t'(0);
    if (!ent.v) ent = '0;
    hist.push_front(ent);
    void'(hist.pop_back());
    if (e_stall && m_stall_cnt < 65535) m_stall_cnt++;
    if (e_stall) begin
      m_wd++;
      if (m_wd >= c_WDOG) m_err = 1'b1;
    end else begin
      m_wd = 0;
    end
    if (!m_halt && id_valid && createdump && !e_stall && !flush_req) m_halt = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, base;
    model_reset();
    #1;
    chk("rst_pc_write", {15'd0, pc_write}, 16'd1);
    chk("rst_ifid_write", {15'd0, ifid_write}, 16'd1);
    chk("rst_idex_bubble", {15'd0, idex_bubble}, 16'd0);
    chk("rst_flush_ifid", {15'd0, flush_ifid}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_w", {10'd0, pc_write_w, ifid_write_w, idex_bubble_w, flush_ifid_w, halted_w, err_w},
        16'b110000);
    chk("rst_w_cnt", stall_cnt_w, 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // ADD r1 then ADD r2 <- r1,r3; decode holds the instruction while stalled
    set_in(1, 0, 0, 0, 0, 3'd1, 1, 0, 0, 0); tick();
    base = m_stall_cnt; n = 0;
    set_in(1, 3'd1, 3'd3, 1, 0, 3'd2, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_pc) break;
      n++;
    end
    chk("raw_stall_cycles", n[15:0], c_EXP_RAW[15:0]);
    chk("raw_stall_cnt", stall_cnt, 16'(base + c_EXP_RAW));
    idle(3);

    // LD r4 then ADD reading r4 as Rt
    set_in(1, 0, 0, 0, 0, 3'd4, 1, 1, 0, 0); tick();
    base = m_stall_cnt; n = 0;
    set_in(1, 3'd0, 3'd4, 0, 1, 3'd5, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!o_bub) break;
      n++;
    end
    chk("ld_use_bubbles", n[15:0], c_EXP_LD[15:0]);
    chk("ld_use_stall_cnt", stall_cnt, 16'(base + c_EXP_LD));
    idle(3);

    // Dependent instruction meets a flush in the same cycle (r0 is a normal register)
    set_in(1, 0, 0, 0, 0, 3'd0, 1, 1, 0, 0); tick();
    base = m_stall_cnt;
    set_in(1, 3'd0, 3'd0, 1, 1, 3'd2, 1, 0, 0, 1); tick();
    chk("flush_pc_write", {15'd0, o_pc}, 16'd1);
    chk("flush_flush_ifid", {15'd0, o_fl}, 16'd1);
    chk("flush_bubble", {15'd0, o_bub}, 16'd1);
    chk("flush_stall_cnt", stall_cnt, base[15:0]);
    idle(3);

    // Random traffic without halts
    for (int i = 0; i < 200; i++) begin
      set_in($urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
             3'($urandom), 1'($urandom), 1'($urandom), 0, $urandom_range(0, 7) == 0);
      tick();
    end
    // Random traffic that may halt
    for (int i = 0; i < 60; i++) begin
      set_in($urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
             3'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 19) == 0,
             $urandom_range(0, 7) == 0);
      tick();
    end

    // HALT with no hazard, then hold for 10 cycles
    do_reset();
    set_in(1, 3'd1, 3'd2, 0, 0, 3'd3, 1, 0, 1, 0); tick();
    chk("halt_issue_bubble", {15'd0, o_bub}, 16'd0);
    for (int i = 0; i < 10; i++) begin
      set_in(1, 3'd3, 3'd3, 1, 1, 3'd3, 1, 1, 0, i[0]); tick();
      chk("halt_halted", {15'd0, halted}, 16'd1);
      chk("halt_pc_write", {15'd0, o_pc}, 16'd0);
      chk("halt_ifid_write", {15'd0, o_ifid}, 16'd0);
      chk("halt_flush_ifid", {15'd0, o_fl}, 16'd0);
    end

    // Asynchronous reset in the middle of a stall
    do_reset();
    set_in(1, 0, 0, 0, 0, 3'd6, 1, 0, 0, 0); tick();
    set_in(1, 3'd6, 3'd0, 1, 0, 3'd7, 1, 1, 0, 0); tick();
    chk("pre_rst_stalled", {15'd0, o_pc}, c_EXP_RAW == 0 ? 16'd1 : 16'd0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_rst_pc_write", {15'd0, pc_write}, 16'd1);
    chk("async_rst_ifid_write", {15'd0, ifid_write}, 16'd1);
    chk("async_rst_bubble", {15'd0, idex_bubble}, 16'd0);
    chk("async_rst_stall_cnt", stall_cnt, 16'd0);
    chk("async_rst_err", {15'd0, err}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    chk("post_rst_run", {15'd0, o_pc}, 16'd1);

    // Watchdog on the deep instance: one producer, reader held 4 cycles
    do_reset();
    set_in(1, 0, 0, 0, 0, 3'd5, 1, 0, 0, 0); tick();
    set_in(1, 3'd5, 3'd0, 1, 0, 3'd1, 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("wdog_err_step", {15'd0, err_w}, (i == 4) ? {15'd0, c_WD_ERR} : 16'd0);
    end
    idle(2);
    chk("wdog_err_sticky", {15'd0, err_w}, {15'd0, c_WD_ERR});
    chk("wdog_pc_free", {15'd0, pc_write_w}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
